// File: rtl/crash_sequencer_if.sv
// crash_sequencer_if: frame/collision inputs and crash-sequence outputs of
// the player crash sequencer. The slave modport is the sequencer's view.
// The master modport is the driving side (game logic or bench).
interface crash_sequencer_if;
  logic       frame_tick;
  logic       colision;
  logic       continue_btn;
  logic       player_freeze;
  logic       respawn_req;
  logic [7:0] respawn_x;
  logic       player_visible;
  logic [1:0] spin_phase;
  logic       invulnerable;
  logic [1:0] lives;
  logic       game_over;
  logic [1:0] state;

  modport slave (
    input  frame_tick, colision, continue_btn,
    output player_freeze, respawn_req, respawn_x, player_visible,
           spin_phase, invulnerable, lives, game_over, state
  );

  modport master (
    output frame_tick, colision, continue_btn,
    input  player_freeze, respawn_req, respawn_x, player_visible,
           spin_phase, invulnerable, lives, game_over, state
  );
endinterface

// File: rtl/crash_sequencer.sv
// crash_sequencer: player crash sequence.
// The sequence is crash -> spin/freeze -> respawn at road centre ->
// blink while invulnerable -> resume. The block also tracks lives and
// game over. Every output is a flop loaded from the next-state logic,
// so colision never reaches an output combinationally.
// Optional feature macro: CRASH_CONTINUE_EN. When it is defined,
// continue_btn in GAME_OVER restarts the game with full lives via RESPAWN.
module crash_sequencer #(
  parameter int SPIN_FRAMES   = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_PERIOD  = 8,
  parameter int LIVES         = 3,
  parameter int ROAD_CENTER_X = 120
) (
  input  logic             clk,
  input  logic             reset,
  crash_sequencer_if.slave cs
);
  localparam int BLINK_BIT = $clog2(BLINK_PERIOD) - 1;

  typedef enum logic [1:0] {
    RUNNING   = 2'd0,
    CRASHED   = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] spin_q, spin_d;
  logic       rq_q, rq_d;
  logic       freeze_q, freeze_d;
  logic       vis_q, vis_d;
  logic       inv_q, inv_d;
  logic       go_q, go_d;

  // Next-state, counter and output decode. Outputs come from the next
  // state so that they line up with state once registered.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    spin_d  = spin_q;
    rq_d    = 1'b0;
    unique case (state_q)
      RUNNING: begin
        if (cs.frame_tick && cs.colision) begin
          if (lives_q > 2'd1) begin
            state_d = CRASHED;
            lives_d = lives_q - 2'd1;
            cnt_d   = '0;
            spin_d  = '0;
          end else begin
            // Last life lost: lives saturate at 0.
            state_d = GAME_OVER;
            lives_d = '0;
          end
        end
      end
      CRASHED: begin
        if (cs.frame_tick) begin
          if (cnt_q == 8'(SPIN_FRAMES - 1)) begin
            state_d = RESPAWN;
            cnt_d   = '0;
            spin_d  = '0;
            rq_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
            // The sprite rotates one step every four frames.
            if (cnt_q[1:0] == 2'd3) spin_d = spin_q + 2'd1;
          end
        end
      end
      RESPAWN: begin
        if (cs.frame_tick) begin
          if (cnt_q == 8'(INVULN_FRAMES - 1)) begin
            state_d = RUNNING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      GAME_OVER: begin
        spin_d = '0;
`ifdef CRASH_CONTINUE_EN
        // Continue does not wait for a frame tick.
        if (cs.continue_btn) begin
          state_d = RESPAWN;
          lives_d = 2'(LIVES);
          cnt_d   = '0;
          rq_d    = 1'b1;
        end
`endif
      end
      default: state_d = RUNNING;
    endcase
    freeze_d = (state_d == CRASHED) || (state_d == GAME_OVER);
    inv_d    = (state_d == RESPAWN);
    go_d     = (state_d == GAME_OVER);
    // The sprite is visible for the first half of each blink period.
    vis_d    = (state_d == RESPAWN) ? ~cnt_d[BLINK_BIT] : 1'b1;
  end

`ifndef CRASH_CONTINUE_EN
  logic unused_continue;
  assign unused_continue = cs.continue_btn;
`endif

  // State and registered outputs. Reset wins over any frame_tick on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUNNING;
      lives_q  <= 2'(LIVES);
      cnt_q    <= '0;
      spin_q   <= '0;
      rq_q     <= 1'b0;
      freeze_q <= 1'b0;
      vis_q    <= 1'b1;
      inv_q    <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      spin_q   <= spin_d;
      rq_q     <= rq_d;
      freeze_q <= freeze_d;
      vis_q    <= vis_d;
      inv_q    <= inv_d;
      go_q     <= go_d;
    end
  end

  assign cs.state          = state_q;
  assign cs.lives          = lives_q;
  assign cs.spin_phase     = spin_q;
  assign cs.respawn_req    = rq_q;
  assign cs.player_freeze  = freeze_q;
  assign cs.player_visible = vis_q;
  assign cs.invulnerable   = inv_q;
  assign cs.game_over      = go_q;
  assign cs.respawn_x      = 8'(ROAD_CENTER_X);
endmodule

// File: tb/tb_crash_sequencer.sv
// tb_crash_sequencer: directed vectors for crash_sequencer with default
// parameters (SPIN 60, INVULN 120, BLINK 8, LIVES 3, x=120).
// Expectations follow CRASH_CONTINUE_EN as seen by this compile.
module tb_crash_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rq_cnt = 0;
  int   base;

  crash_sequencer_if cif();

  crash_sequencer dut (.clk(clk), .reset(reset), .cs(cif.slave));

  always #5 clk = ~clk;

  // Count respawn pulses away from the active edge.
  always @(negedge clk) if (cif.respawn_req === 1'b1) rq_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic ft);
    cif.frame_tick = ft;
    @(posedge clk);
    #1;
    cif.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"},   int'(cif.state), 0);
    chk({tag, " lives"},   int'(cif.lives), 3);
    chk({tag, " freeze"},  int'(cif.player_freeze), 0);
    chk({tag, " rq"},      int'(cif.respawn_req), 0);
    chk({tag, " visible"}, int'(cif.player_visible), 1);
    chk({tag, " invuln"},  int'(cif.invulnerable), 0);
    chk({tag, " gameover"},int'(cif.game_over), 0);
    chk({tag, " spin"},    int'(cif.spin_phase), 0);
    chk({tag, " rx"},      int'(cif.respawn_x), 120);
  endtask

  // One full crash: collision tick, 60 spin frames, 120 invulnerable frames.
  task automatic crash_cycle();
    cif.colision = 1'b1;
    cyc(1'b1);
    cif.colision = 1'b0;
    ticks(60);
    ticks(120);
  endtask

  initial begin
    cif.frame_tick   = 1'b0;
    cif.colision     = 1'b0;
    cif.continue_btn = 1'b0;
    do_reset();
    chk_reset_vals("reset");

    // A collision without a frame tick is ignored.
    base = rq_cnt;
    cif.colision = 1'b1;
    repeat (100) cyc(1'b0);
    chk("notick state", int'(cif.state), 0);
    chk("notick lives", int'(cif.lives), 3);
    chk("notick rq", rq_cnt - base, 0);

    // A collision on a tick starts the crash.
    cyc(1'b1);
    cif.colision = 1'b0;
    chk("crash state", int'(cif.state), 1);
    chk("crash lives", int'(cif.lives), 2);
    chk("crash freeze", int'(cif.player_freeze), 1);
    ticks(4);
    chk("spin4", int'(cif.spin_phase), 1);
    ticks(12);
    chk("spin16", int'(cif.spin_phase), 0);
    ticks(43);
    chk("spin59 state", int'(cif.state), 1);
    base = rq_cnt;
    cyc(1'b1);
    chk("respawn state", int'(cif.state), 2);
    chk("respawn rq", int'(cif.respawn_req), 1);
    chk("respawn rx", int'(cif.respawn_x), 120);
    chk("respawn invuln", int'(cif.invulnerable), 1);
    chk("respawn freeze", int'(cif.player_freeze), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("blink%0d", i), int'(cif.player_visible), (i < 4) ? 1 : 0);
      cyc(1'b1);
    end
    chk("rq one cycle", int'(cif.respawn_req), 0);
    ticks(111);
    chk("invuln119 state", int'(cif.state), 2);
    cyc(1'b1);
    chk("resume state", int'(cif.state), 0);
    chk("resume visible", int'(cif.player_visible), 1);
    chk("resume invuln", int'(cif.invulnerable), 0);
    chk("rq pulses", rq_cnt - base, 1);

    // Held collision counts once; the first RUNNING tick counts again.
    do_reset();
    cif.colision = 1'b1;
    cyc(1'b1);
    chk("held crash lives", int'(cif.lives), 2);
    ticks(60);
    chk("held respawn state", int'(cif.state), 2);
    chk("held respawn lives", int'(cif.lives), 2);
    ticks(120);
    chk("held resume state", int'(cif.state), 0);
    chk("held resume lives", int'(cif.lives), 2);
    cyc(1'b1);
    cif.colision = 1'b0;
    chk("second crash lives", int'(cif.lives), 1);
    chk("second crash state", int'(cif.state), 1);

    // Reset on the edge that would have ended the spin.
    ticks(59);
    base = rq_cnt;
    reset = 1'b1;
    cyc(1'b1);
    reset = 1'b0;
    chk_reset_vals("midreset");
    cyc(1'b0);
    cyc(1'b0);
    chk("midreset rq", rq_cnt - base, 0);

    // Run out of lives.
    crash_cycle();
    crash_cycle();
    chk("two crashes lives", int'(cif.lives), 1);
    chk("two crashes state", int'(cif.state), 0);
    cif.colision = 1'b1;
    cyc(1'b1);
    chk("gameover state", int'(cif.state), 3);
    chk("gameover lives", int'(cif.lives), 0);
    chk("gameover flag", int'(cif.game_over), 1);
    chk("gameover freeze", int'(cif.player_freeze), 1);
    chk("gameover visible", int'(cif.player_visible), 1);
    chk("gameover spin", int'(cif.spin_phase), 0);
    cyc(1'b1);
    cif.colision = 1'b0;
    chk("lives saturate", int'(cif.lives), 0);
    chk("gameover holds", int'(cif.state), 3);

    base = rq_cnt;
    cif.continue_btn = 1'b1;
    cyc(1'b0);
    cif.continue_btn = 1'b0;
`ifdef CRASH_CONTINUE_EN
    chk("continue state", int'(cif.state), 2);
    chk("continue lives", int'(cif.lives), 3);
    chk("continue rq", int'(cif.respawn_req), 1);
    chk("continue invuln", int'(cif.invulnerable), 1);
    cyc(1'b0);
    chk("continue pulses", rq_cnt - base, 1);
`else
    chk("continue state", int'(cif.state), 3);
    chk("continue lives", int'(cif.lives), 0);
    chk("continue rq", int'(cif.respawn_req), 0);
    chk("continue flag", int'(cif.game_over), 1);
    cyc(1'b0);
    chk("continue pulses", rq_cnt - base, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
